// File: rtl/fetch_stage_if.sv
// fetch_stage_if: single-outstanding instruction-memory request/ready bus
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;
  modport master(output req, addr, input rdata, ready);
  modport slave(input req, addr, output rdata, ready);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS fetch PC, imem handshake and IF/ID register with delay-slot redirect
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [1:0]          pc_control,
  input  logic [31:0]         jr_target,
  fetch_stage_if.master       imem,
  output logic [31:0]         instr_d,
  output logic [31:0]         pc4_d,
  output logic [31:0]         pc8_d,
  output logic                valid_d
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      state;
  logic [31:0] pc_f, redir_pc, hold_buf, hold_pc4, target, next_pc;
  logic        redir_pend, sample, consume;
  always_comb begin
    target  = pc_control == 2'd1 ? pc4_d + {{14{instr_d[15]}}, instr_d[15:0], 2'b00} :
              pc_control == 2'd3 ? {pc4_d[31:28], instr_d[25:0], 2'b00} :
              jr_target & ~32'd3;
    sample  = valid_d && !stall && pc_control != 2'd0;
    // a redirect sampled in the same cycle the delay slot lands bypasses redir_pc
    next_pc = sample ? target : redir_pend ? redir_pc : pc_f + 32'd4;
    consume = !stall && (state == HOLD || imem.ready);
  end
  assign imem.req  = state == FETCH;
  assign imem.addr = pc_f;
  assign pc8_d     = pc4_d + 32'd4;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f       <= RESET_PC;
      state      <= FETCH;
      instr_d    <= NOP_INSTR;
      pc4_d      <= 32'd0;
      valid_d    <= 1'b0;
      redir_pend <= 1'b0;
      hold_buf   <= 32'd0;
      hold_pc4   <= 32'd0;
    end else begin
      if (consume) begin
        pc_f       <= next_pc;
        redir_pend <= 1'b0;
        instr_d    <= state == HOLD ? hold_buf : imem.rdata;
        pc4_d      <= state == HOLD ? hold_pc4 : pc_f + 32'd4;
        valid_d    <= 1'b1;
        state      <= FETCH;
      end else if (sample) begin
        redir_pend <= 1'b1;
        redir_pc   <= target;
      end
      if (state == FETCH && imem.ready && stall) begin
        hold_buf <= imem.rdata;
        hold_pc4 <= pc_f + 32'd4;
        state    <= HOLD;
      end
      if (state == FETCH && !imem.ready && !stall) begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch stimulus checked against a program-order reference model
module tb_fetch_stage;
  localparam logic [31:0] RST = 32'h0000_3000;
  logic clk = 1'b0, reset, stall, valid_d;
  logic [1:0] pc_control;
  logic [31:0] jr_target, instr_d, pc4_d, pc8_d;
  fetch_stage_if imem();
  fetch_stage dut (.clk(clk), .reset(reset), .stall(stall), .pc_control(pc_control),
                   .jr_target(jr_target), .imem(imem), .instr_d(instr_d), .pc4_d(pc4_d),
                   .pc8_d(pc8_d), .valid_d(valid_d));
  always #5 clk = ~clk;
  int total = 0, bad = 0, last_cls = 0;
  bit chk_en = 0;
  logic m_buf = 1'b0, e_valid = 1'b0, s_valid, s_req;
  logic [31:0] m_addr = RST, m_bufw, e_instr = 0, e_pc4 = 0, last_tgt, last_jr;
  logic [31:0] s_addr, s_instr, s_pc8;
  int plan_cls[$];
  logic [31:0] plan_jr[$];
  logic [31:0] ovr[logic [31:0]];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] memw(input logic [31:0] a);
    return ovr.exists(a) ? ovr[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  function automatic logic [31:0] tgt(input int c, input logic [31:0] w, input logic [31:0] pc4,
                                     input logic [31:0] jr);
    if (c == 1) return pc4 + 32'(4 * $signed(w[15:0]));
    if (c == 3) return (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    return jr & ~32'd3;
  endfunction
  // instruction k+1 is fetched from the target of instruction k-1 when k-1 redirects
  task automatic deliver(input logic [31:0] w);
    int c;
    logic [31:0] jr, nxt;
    c  = $urandom_range(0, 9);
    c  = c < 7 ? 0 : c - 6;
    jr = $urandom;
    if (plan_cls.size() > 0) begin
      c  = plan_cls.pop_front();
      jr = plan_jr.pop_front();
    end
    if (last_cls != 0) c = 0;
    nxt      = last_cls != 0 ? last_tgt : m_addr + 32'd4;
    e_instr  = w;
    e_pc4    = m_addr + 32'd4;
    e_valid  = 1'b1;
    last_cls = c;
    last_jr  = jr;
    last_tgt = tgt(c, w, m_addr + 32'd4, jr);
    m_addr   = nxt;
    m_buf    = 1'b0;
  endtask
  task automatic tick(input bit rs, input int rdy, input int stl);
    reset       = rs;
    stall       = stl == 2 ? ($urandom_range(0, 99) < 20) : stl[0];
    imem.ready  = m_buf ? 1'b0 : rdy == 2 ? ($urandom_range(0, 99) < 60) : rdy[0];
    imem.rdata  = imem.ready ? memw(m_addr) : $urandom;
    pc_control  = (e_valid && !stall) ? 2'(last_cls) : 2'($urandom);
    jr_target   = (e_valid && !stall && last_cls == 2) ? last_jr : $urandom;
    @(negedge clk);
    s_addr = imem.addr; s_instr = instr_d; s_pc8 = pc8_d; s_valid = valid_d; s_req = imem.req;
    @(posedge clk);
    if (reset) begin
      m_addr = RST; m_buf = 1'b0; e_instr = 0; e_pc4 = 0; e_valid = 1'b0; last_cls = 0;
    end else if (m_buf) begin
      if (!stall) deliver(m_bufw);
    end else if (imem.ready) begin
      if (stall) begin
        m_buf  = 1'b1;
        m_bufw = imem.rdata;
      end else deliver(imem.rdata);
    end else if (!stall) begin
      e_instr = 0;
      e_valid = 1'b0;
    end
    #1;
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("req", imem.req, !m_buf);
    chk("addr", imem.addr, m_addr);
    chk("instr_d", instr_d, e_instr);
    chk("pc4_d", pc4_d, e_pc4);
    chk("pc8_d", pc8_d, e_pc4 + 32'd4);
    chk("valid_d", valid_d, e_valid);
  end
  initial begin
    logic [31:0] ea[6] = '{32'h3000, 32'h3004, 32'h3000, 32'h3004, 32'h3100, 32'h3104};
    logic [31:0] ew[5] = '{32'h3000, 32'h3004, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    tick(1, 1, 0);
    chk_en = 1;
    ovr[32'h3000] = 32'h1000_FFFF;
    plan_cls = '{1, 0, 2, 0};
    plan_jr  = '{32'h0, 32'h0, 32'h3103, 32'h0};
    tick(1, 1, 0);
    for (int c = 0; c < 6; c++) begin
      tick(0, 1, 0);
      chk("seq_addr", s_addr, ea[c]);
      if (c == 0) chk("first_valid", s_valid, 0);
      if (c == 1) begin
        chk("beq_instr", s_instr, 32'h1000_FFFF);
        chk("beq_pc8", s_pc8, 32'h3008);
      end
      if (c == 2) chk("slot_valid", s_valid, 1);
    end
    ovr[32'h3000] = 32'h0C00_0C10;
    plan_cls = '{3, 0};
    plan_jr  = '{32'h0, 32'h0};
    tick(1, 1, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("jal_pc8", s_pc8, 32'h3008);
    tick(0, 0, 0);
    chk("bubble_valid", s_valid, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("slot_addr", s_addr, 32'h3004);
    tick(0, 1, 0);
    chk("jal_target", s_addr, 32'h3040);
    plan_cls = '{2, 0, 0, 0, 0, 0};
    plan_jr  = '{32'hFFFF_FFFA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tick(1, 1, 0);
    for (int c = 0; c < 5; c++) begin
      tick(0, 1, 0);
      chk("wrap_addr", s_addr, ew[c]);
    end
    tick(0, 1, 1);
    tick(0, 1, 1);
    chk("hold_req", s_req, 0);
    chk("hold_instr", s_instr, memw(32'h0));
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("release_instr", s_instr, memw(32'h4));
    chk("release_addr", s_addr, 32'h8);
    chk("release_pc8", s_pc8, 32'hC);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        tick(0, 2, 0);
        tick(1, 1, 2);
        tick(0, 2, 2);
        chk("rst_addr", s_addr, RST);
        chk("rst_valid", s_valid, 0);
      end else tick(0, 2, 2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
